branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/target width.
REQ-002 SHALL have parameter ENTRIES, default 64: BTB/BHT entry count, power of two, 4..1024.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_pc  input  XLEN  fetch-stage PC to look up.
REQ-006 SHALL have port pred_taken  output  1  predicts the fetch PC redirects.
REQ-007 SHALL have port pred_target  output  XLEN  predicted next PC, valid when pred_taken=1.
REQ-008 SHALL have port upd_valid  input  1  EX-stage resolved control-transfer update strobe.
REQ-009 SHALL have port upd_pc  input  XLEN  PC of the resolved instruction.
REQ-010 SHALL have port upd_is_jump  input  1  1=JAL/JALR, 0=conditional branch.
REQ-011 SHALL have port upd_taken  input  1  actual outcome.
REQ-012 SHALL have port upd_target  input  XLEN  actual target.
REQ-013 SHALL have port upd_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-014 SHALL have port upd_pred_target  input  XLEN  predicted target carried down the pipe.
REQ-015 SHALL have port mispredict  output  1  combinational; asserted when the EX redirect must flush.
REQ-016 SHALL have port invalidate  input  1  clear all entries (fence.i).
REQ-017 SHALL have port lookup_count  output  32  number of IF lookups counted since reset.
REQ-018 SHALL have port mispredict_count  output  32  number of mispredicts counted since reset.

Function
REQ-019 SHALL use a direct-mapped table: index = pc[log2(ENTRIES)+1:2], tag = pc[XLEN-1:log2(ENTRIES)+2]; each entry = valid, tag, target, 2-bit counter.
REQ-020 SHALL produce the lookup combinationally (zero latency) and assert pred_taken = valid && tag match && counter[1].
REQ-021 SHALL drive pred_target = stored target on hit, otherwise if_pc+4.
REQ-022 SHALL compute mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
REQ-023 SHALL, on upd_valid with a tag hit, saturate the counter up when taken and down when not taken, and write upd_target when taken.
REQ-024 SHALL, on upd_valid with a miss and upd_taken=1, allocate the entry (overwriting any occupant): valid=1, tag, target, counter=WT (10).
REQ-025 SHALL NOT allocate on a miss with upd_taken=0.
REQ-026 SHALL force the counter to ST (11) for any update with upd_is_jump=1.
REQ-027 SHALL give a same-cycle lookup and update at the same index the pre-update entry (no bypass); the new state becomes visible the next cycle.
REQ-028 SHALL, on invalidate, clear every valid bit at the next edge; invalidate SHALL override a concurrent update, and no allocation SHALL occur that cycle.
REQ-029 SHALL increment lookup_count every cycle out of reset, and increment mispredict_count on cycles where mispredict=1; both counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-030 SHALL, on reset_n low, immediately clear all valid bits, set all counters to WNT (01), and zero both statistics counters; tag and target contents are don't-care.
REQ-031 SHALL, while reset_n is low, drive pred_taken=0 and pred_target=if_pc+4; an update in flight when reset asserts SHALL be discarded.

Structure
REQ-032 SHALL take the counter encodings SNT=00, WNT=01, WT=10, ST=11 and the saturating increment/decrement rules from a shared package, bp_pkg.
REQ-033 SHALL implement the saturating 2-bit counter update as one sub-module, bp_sat_counter; the table SHALL be flops (no SRAM macro).

Verification
REQ-034 Bench SHALL show: reset, then lookup at 0x100 -> pred_taken=0, pred_target=0x104, lookup_count increments each cycle.
REQ-035 Bench SHALL show: update pc=0x100, taken, target 0x80 -> the next-cycle lookup at 0x100 gives pred_taken=1, target 0x80; two not-taken updates -> pred_taken=0.
REQ-036 Bench SHALL show: ENTRIES=64, taken updates at 0x100 then 0x200 (same index, different tag) -> lookup at 0x100 misses and 0x200 hits.
REQ-037 Bench SHALL show: JAL update at 0x40, target 0x400, then one not-taken branch update at 0x40 -> the counter drops to WT and the lookup is still taken.
REQ-038 Bench SHALL show: upd_pred_taken=1, pred target 0x80, actual target 0x90 -> mispredict=1 and mispredict_count +1; a concurrent invalidate with an update -> all lookups miss the next cycle.
REQ-039 Bench SHALL show: reset_n asserted mid-update -> no entry written and all outputs at their reset values.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: 2-bit counter encodings and saturating increment/decrement rules shared by the branch predictor
package bp_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;
  function automatic ctr_t sat_inc(ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction
  function automatic ctr_t sat_dec(ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next 2-bit counter state (cur in, taken/jump in, nxt out); jumps force strongly-taken
import bp_pkg::*;
module bp_sat_counter (
  input  ctr_t cur,
  input  logic taken,
  input  logic jump,
  output ctr_t nxt
);
  always_comb nxt = jump ? ST : taken ? sat_inc(cur) : sat_dec(cur);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB+BHT; if_pc lookup -> pred_taken/pred_target, upd_* resolve -> mispredict and table write, invalidate clears, lookup/mispredict counters
import bp_pkg::*;
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  input  logic            invalidate,
  output logic [31:0]     lookup_count,
  output logic [31:0]     mispredict_count
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];
  logic [IW-1:0]      l_idx, u_idx;
  logic [TW-1:0]      l_tag, u_tag;
  logic               l_hit, u_hit, wr;
  ctr_t               u_cur, u_nxt;
  always_comb begin
    l_idx       = if_pc[IW+1:2];
    l_tag       = if_pc[XLEN-1:IW+2];
    l_hit       = reset_n && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = l_hit && ctr_q[l_idx][1];
    pred_target = l_hit ? tgt_q[l_idx] : if_pc + XLEN'(4);
    u_idx       = upd_pc[IW+1:2];
    u_tag       = upd_pc[XLEN-1:IW+2];
    u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    // a fresh allocation starts from WNT so one taken step lands on WT
    u_cur       = u_hit ? ctr_q[u_idx] : WNT;
    wr          = reset_n && upd_valid && !invalidate && (u_hit || upd_taken);
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));
  end
  bp_sat_counter u_ctr (.cur(u_cur), .taken(upd_taken), .jump(upd_is_jump), .nxt(u_nxt));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q          <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (invalidate) valid_q <= '0;
      else if (wr) valid_q[u_idx] <= 1'b1;
      if (wr) ctr_q[u_idx] <= u_nxt;
      if (lookup_count != '1) lookup_count <= lookup_count + 32'd1;
      if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
    end
  end
  // tag/target need no reset: they are only observed behind a set valid bit
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_q[u_idx] <= u_tag;
      if (upd_taken) tgt_q[u_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed table plus randomized checks against a behavioural table model
module tb_branch_predictor;
  localparam int XLEN = 32;
  localparam int ENTRIES = 64;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [31:0] if_pc = 32'h100, upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic upd_valid = 1'b0, upd_is_jump = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0, invalidate = 1'b0;
  logic pred_taken, mispredict;
  logic [31:0] pred_target, lookup_count, mispredict_count;
  int checks = 0, errors = 0;
  bit          mv   [ENTRIES];
  int unsigned mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  int          mctr [ENTRIES];
  int unsigned m_look, m_mis;
  typedef struct {
    logic [31:0] pc;
    logic uv, uj, ut;
    logic [31:0] upc, utgt;
    logic upt;
    logic [31:0] uptgt;
    logic inv;
    logic e_taken;
    logic [31:0] e_tgt;
    logic e_mis;
  } vec_t;
  vec_t vt [16];
  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .invalidate(invalidate), .lookup_count(lookup_count),
    .mispredict_count(mispredict_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] pc, input logic uv, uj, ut, input logic [31:0] upc, utgt,
                              input logic upt, input logic [31:0] uptgt, input logic inv,
                              input logic et, input logic [31:0] etg, input logic em);
    vec_t v;
    v.pc = pc; v.uv = uv; v.uj = uj; v.ut = ut; v.upc = upc; v.utgt = utgt; v.upt = upt;
    v.uptgt = uptgt; v.inv = inv; v.e_taken = et; v.e_tgt = etg; v.e_mis = em;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    if_pc = v.pc; upd_valid = v.uv; upd_is_jump = v.uj; upd_taken = v.ut; upd_pc = v.upc;
    upd_target = v.utgt; upd_pred_taken = v.upt; upd_pred_target = v.uptgt; invalidate = v.inv;
  endtask
  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin mv[i] = 0; mctr[i] = 1; end
    m_look = 0; m_mis = 0;
  endtask
  // caller sits just after a negedge; returns at the following negedge
  task automatic step(input vec_t v);
    int unsigned li, lt, ui, ut;
    bit lhit, uhit, emis;
    apply(v);
    li = (v.pc / 4) % ENTRIES; lt = v.pc / (4 * ENTRIES);
    ui = (v.upc / 4) % ENTRIES; ut = v.upc / (4 * ENTRIES);
    lhit = mv[li] && mtag[li] == lt;
    uhit = mv[ui] && mtag[ui] == ut;
    emis = v.uv && ((v.ut != v.upt) || (v.ut && v.utgt != v.uptgt));
    #2;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, lhit && mctr[li] >= 2});
    chk("pred_target", pred_target, lhit ? mtgt[li] : v.pc + 32'd4);
    chk("mispredict", {31'd0, mispredict}, {31'd0, emis});
    chk("lookup_count", lookup_count, m_look);
    chk("mispredict_count", mispredict_count, m_mis);
    @(posedge clk);
    m_look++;
    if (emis) m_mis++;
    if (v.inv) begin
      for (int i = 0; i < ENTRIES; i++) mv[i] = 0;
    end else if (v.uv && uhit) begin
      mctr[ui] = v.uj ? 3 : v.ut ? (mctr[ui] == 3 ? 3 : mctr[ui] + 1) : (mctr[ui] == 0 ? 0 : mctr[ui] - 1);
      if (v.ut) mtgt[ui] = v.utgt;
    end else if (v.uv && v.ut) begin
      mv[ui] = 1; mtag[ui] = ut; mtgt[ui] = v.utgt; mctr[ui] = v.uj ? 3 : 2;
    end
    @(negedge clk);
  endtask
  initial begin
    int unsigned msum;
    vec_t r;
    vt[0]  = mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h104, 0);
    vt[1]  = mk(32'h100, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104, 0,         0, 32'h104, 1);
    vt[2]  = mk(32'h100, 1, 0, 0, 32'h100, 0, 1, 32'h80, 0,               1, 32'h80, 1);
    vt[3]  = mk(32'h100, 1, 0, 0, 32'h100, 0, 0, 32'h104, 0,              0, 32'h80, 0);
    vt[4]  = mk(32'h100, 1, 0, 1, 32'h200, 32'h300, 0, 32'h204, 0,        0, 32'h80, 1);
    vt[5]  = mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h104, 0);
    vt[6]  = mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 0,                            1, 32'h300, 0);
    vt[7]  = mk(32'h40,  1, 1, 1, 32'h40, 32'h400, 0, 32'h44, 0,          0, 32'h44, 1);
    vt[8]  = mk(32'h40,  1, 0, 0, 32'h40, 0, 1, 32'h400, 0,               1, 32'h400, 1);
    vt[9]  = mk(32'h40,  0, 0, 0, 0, 0, 0, 0, 0,                            1, 32'h400, 0);
    vt[10] = mk(32'h40,  1, 0, 1, 32'h40, 32'h90, 1, 32'h80, 0,           1, 32'h400, 1);
    vt[11] = mk(32'h40,  0, 0, 0, 0, 0, 0, 0, 0,                            1, 32'h90, 0);
    vt[12] = mk(32'h200, 1, 0, 1, 32'h500, 32'h600, 0, 32'h504, 1,       1, 32'h300, 1);
    vt[13] = mk(32'h500, 0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h504, 0);
    vt[14] = mk(32'h40,  0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h44, 0);
    vt[15] = mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 0,                            0, 32'h204, 0);
    #1 reset_n = 1'b0;
    #20;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h104);
    chk("rst_lookup_count", lookup_count, 32'd0);
    chk("rst_mispredict_count", mispredict_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    msum = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #2;
      chk($sformatf("row%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vt[i].e_taken});
      chk($sformatf("row%0d_pred_target", i), pred_target, vt[i].e_tgt);
      chk($sformatf("row%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vt[i].e_mis});
      chk($sformatf("row%0d_lookup_count", i), lookup_count, i + 1);
      chk($sformatf("row%0d_mispredict_count", i), mispredict_count, msum);
      msum += vt[i].e_mis;
    end
    @(negedge clk);
    apply(mk(32'h700, 1, 0, 1, 32'h700, 32'h800, 0, 32'h704, 0, 0, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("midrst_pred_target", pred_target, 32'h704);
    chk("midrst_lookup_count", lookup_count, 32'd0);
    chk("midrst_mispredict_count", mispredict_count, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_edge_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("midrst_edge_lookup_count", lookup_count, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    step(mk(32'h700, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("midrst_no_alloc", {31'd0, pred_taken}, 32'd0);
    step(mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 400; n++) begin
      r.pc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      r.uv    = $urandom_range(0, 3) != 0;
      r.uj    = $urandom_range(0, 3) == 0;
      r.ut    = r.uj || $urandom_range(0, 1) == 1;
      r.upc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      r.utgt  = $urandom_range(0, 15) << 4;
      r.upt   = $urandom_range(0, 1) == 1;
      r.uptgt = $urandom_range(0, 1) == 1 ? r.utgt : ($urandom_range(0, 15) << 4);
      r.inv   = $urandom_range(0, 39) == 0;
      r.e_taken = 0; r.e_tgt = 0; r.e_mis = 0;
      step(r);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
